// File: rtl/rf_write_scheduler.sv
// Register-file write-port owner: arbitrates WB against a long-latency unit,
// tracks LLU destinations in a busy scoreboard and raises decode hazards.
module rf_write_scheduler #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_wren,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_data,
   input  logic            ll_valid,
   input  logic [4:0]      ll_rd,
   input  logic [XLEN-1:0] ll_data,
   output logic            ll_ready,
   input  logic            ll_issue,
   input  logic [4:0]      ll_issue_rd,
   input  logic [4:0]      dec_rs1,
   input  logic [4:0]      dec_rs2,
   input  logic [4:0]      dec_rd,
   input  logic            dec_rs1_rden,
   input  logic            dec_rs2_rden,
   input  logic            dec_rd_wren,
   output logic            dec_hazard,
   output logic            pipe_stall,
   output logic            rf_wren,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_data
);

   localparam logic [0:0] ARB   = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;
   localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

   logic [0:0]  state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] busy_reg, busy_next;
   logic [31:0] set_vec, clr_vec, eff_busy;
   logic        in_drain, pipe_grant, ll_grant;

   // In DRAIN the pipe is locked out even when the LLU has nothing to give.
   always_comb begin
      in_drain   = (state_reg == DRAIN);
      pipe_grant = !in_drain && pipe_wren;
      ll_grant   = ll_valid && (in_drain || !pipe_wren);
   end

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_sb
         if (gi == 0) begin : g_x0
            assign set_vec[gi]   = 1'b0;
            assign clr_vec[gi]   = 1'b0;
            assign eff_busy[gi]  = busy_reg[gi];
            assign busy_next[gi] = 1'b0;
         end else begin : g_xn
            assign set_vec[gi]   = ll_issue && (ll_issue_rd == 5'(gi));
            assign clr_vec[gi]   = ll_grant && (ll_rd == 5'(gi));
            // Same-cycle retirement is visible to decode through RF bypass.
            assign eff_busy[gi]  = busy_reg[gi] && !clr_vec[gi];
            assign busy_next[gi] = set_vec[gi] || eff_busy[gi];
         end
      end
   endgenerate

   always_comb begin
      state_next = ARB;
      cnt_next   = 4'd0;
      if (!in_drain && ll_valid && pipe_wren) begin
         if (cnt_reg == CNT_LAST) begin
            state_next = DRAIN;
         end else begin
            cnt_next = cnt_reg + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ARB;
         cnt_reg   <= 4'd0;
         busy_reg  <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         busy_reg  <= busy_next;
      end
   end

   always_comb begin
      ll_ready   = rst_n && ll_grant;
      pipe_stall = rst_n && in_drain;
      dec_hazard = rst_n && ((dec_rs1_rden && eff_busy[dec_rs1]) ||
                             (dec_rs2_rden && eff_busy[dec_rs2]) ||
                             (dec_rd_wren  && eff_busy[dec_rd]));
      rf_wren    = 1'b0;
      rf_rd      = 5'd0;
      rf_data    = '0;
      if (rst_n && pipe_grant) begin
         rf_wren = (pipe_rd != 5'd0);
         rf_rd   = pipe_rd;
         rf_data = pipe_data;
      end else if (rst_n && ll_grant) begin
         rf_wren = (ll_rd != 5'd0);
         rf_rd   = ll_rd;
         rf_data = ll_data;
      end
   end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed vector table, hand-written starvation
// and reset sequences, then random traffic against a behavioural model.
module tb_rf_write_scheduler;

   localparam int XLEN       = 32;
   localparam int STARVE_MAX = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            pipe_wren = 1'b0, ll_valid = 1'b0, ll_issue = 1'b0;
   logic [4:0]      pipe_rd = '0, ll_rd = '0, ll_issue_rd = '0;
   logic [XLEN-1:0] pipe_data = '0, ll_data = '0;
   logic [4:0]      dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
   logic            dec_rs1_rden = 1'b0, dec_rs2_rden = 1'b0, dec_rd_wren = 1'b0;
   logic            ll_ready, dec_hazard, pipe_stall, rf_wren;
   logic [4:0]      rf_rd;
   logic [XLEN-1:0] rf_data;

   int checks = 0;
   int failures = 0;

   rf_write_scheduler #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_wren(pipe_wren), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
      .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_rs1_rden(dec_rs1_rden), .dec_rs2_rden(dec_rs2_rden), .dec_rd_wren(dec_rd_wren),
      .dec_hazard(dec_hazard), .pipe_stall(pipe_stall),
      .rf_wren(rf_wren), .rf_rd(rf_rd), .rf_data(rf_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          pw;
      logic [4:0]  prd;
      logic [31:0] pdat;
      bit          lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      bit          iss;
      logic [4:0]  ird;
      logic [4:0]  rs1, rs2, rd;
      bit          e1, e2, e3;
      bit          x_ready, x_stall, x_wren, x_haz;
      logic [4:0]  x_rd;
      logic [31:0] x_data;
   } vec_t;

   // Reference model: busy set, count of consecutive lost arbitrations,
   // and whether the current cycle is the forced LLU slot.
   bit [31:0] m_busy = '0;
   int        m_streak = 0;
   bit        m_drain = 1'b0;

   function automatic vec_t idle();
      vec_t v;
      v = '{default: '0};
      v.rst = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit hz(input bit en, input logic [4:0] r, input bit clr, input logic [4:0] crd);
      return en && (r != 5'd0) && m_busy[r] && !(clr && crd == r);
   endfunction

   task automatic run(input vec_t v, input bit use_exp, input string tag);
      bit          e_ready, e_stall, e_wren, e_haz;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      rst_n = v.rst; pipe_wren = v.pw; pipe_rd = v.prd; pipe_data = v.pdat;
      ll_valid = v.lv; ll_rd = v.lrd; ll_data = v.ldat;
      ll_issue = v.iss; ll_issue_rd = v.ird;
      dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.rd;
      dec_rs1_rden = v.e1; dec_rs2_rden = v.e2; dec_rd_wren = v.e3;
      @(negedge clk);
      e_ready = 0; e_stall = 0; e_wren = 0; e_haz = 0; e_rd = '0; e_data = '0;
      if (v.rst) begin
         if (m_drain) begin
            e_stall = 1;
            if (v.lv) begin e_ready = 1; e_wren = (v.lrd != 0); e_rd = v.lrd; e_data = v.ldat; end
         end else if (v.pw) begin
            e_wren = (v.prd != 0); e_rd = v.prd; e_data = v.pdat;
         end else if (v.lv) begin
            e_ready = 1; e_wren = (v.lrd != 0); e_rd = v.lrd; e_data = v.ldat;
         end
         e_haz = hz(v.e1, v.rs1, e_ready, v.lrd) || hz(v.e2, v.rs2, e_ready, v.lrd) ||
                 hz(v.e3, v.rd, e_ready, v.lrd);
      end
      chk({tag, " ll_ready"}, 32'(ll_ready), 32'(e_ready));
      chk({tag, " pipe_stall"}, 32'(pipe_stall), 32'(e_stall));
      chk({tag, " rf_wren"}, 32'(rf_wren), 32'(e_wren));
      chk({tag, " dec_hazard"}, 32'(dec_hazard), 32'(e_haz));
      if (e_wren) begin
         chk({tag, " rf_rd"}, 32'(rf_rd), 32'(e_rd));
         chk({tag, " rf_data"}, rf_data, e_data);
      end
      if (use_exp) begin
         chk({tag, " tbl ll_ready"}, 32'(ll_ready), 32'(v.x_ready));
         chk({tag, " tbl pipe_stall"}, 32'(pipe_stall), 32'(v.x_stall));
         chk({tag, " tbl rf_wren"}, 32'(rf_wren), 32'(v.x_wren));
         chk({tag, " tbl dec_hazard"}, 32'(dec_hazard), 32'(v.x_haz));
         if (v.x_wren) begin
            chk({tag, " tbl rf_rd"}, 32'(rf_rd), 32'(v.x_rd));
            chk({tag, " tbl rf_data"}, rf_data, v.x_data);
         end
         $display("%s: ready=%0d stall=%0d wren=%0d rd=%0d data=%h haz=%0d", tag,
                  ll_ready, pipe_stall, rf_wren, rf_rd, rf_data, dec_hazard);
      end
      if (!v.rst) begin
         m_busy = '0; m_streak = 0; m_drain = 0;
      end else begin
         if (m_drain) begin
            m_drain = 0; m_streak = 0;
         end else if (v.lv && v.pw) begin
            m_streak++;
            if (m_streak == STARVE_MAX) begin m_drain = 1; m_streak = 0; end
         end else begin
            m_streak = 0;
         end
         if (e_ready && v.lrd != 0) m_busy[v.lrd] = 1'b0;
         if (v.iss && v.ird != 0) m_busy[v.ird] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Pipe and LLU both contend; used for starvation sequences.
   function automatic vec_t contend(input int k);
      vec_t v;
      v = idle();
      v.pw = 1; v.prd = 5'd4; v.pdat = 32'h1000 + 32'(k);
      v.lv = 1; v.lrd = 5'd9; v.ldat = 32'hA5A5_0000 + 32'(k);
      v.x_wren = 1; v.x_rd = 5'd4; v.x_data = v.pdat;
      return v;
   endfunction

   function automatic vec_t drain_slot(input vec_t c);
      vec_t v;
      v = c;
      v.x_stall = 1; v.x_ready = 1; v.x_rd = 5'd9; v.x_data = c.ldat;
      return v;
   endfunction

   vec_t tbl[$];
   vec_t v;

   initial begin
      // Directed table: reset, RAW on busy, same-cycle clear, x0 rules, set-wins.
      v = idle(); v.rst = 0; v.pw = 1; v.prd = 3; v.lv = 1; v.lrd = 2; v.e1 = 1; v.rs1 = 1;
      tbl.push_back(v);
      v = idle(); v.iss = 1; v.ird = 5; tbl.push_back(v);
      v = idle(); v.rs1 = 5; v.e1 = 1; v.x_haz = 1; tbl.push_back(v);
      v = idle(); v.lv = 1; v.lrd = 5; v.ldat = 32'hDEADBEEF; v.rs1 = 5; v.e1 = 1;
      v.x_ready = 1; v.x_wren = 1; v.x_rd = 5; v.x_data = 32'hDEADBEEF; tbl.push_back(v);
      v = idle(); v.rs1 = 5; v.e1 = 1; tbl.push_back(v);
      v = idle(); v.lv = 1; v.lrd = 0; v.ldat = 32'h1234; v.x_ready = 1; tbl.push_back(v);
      v = idle(); v.iss = 1; v.ird = 0; v.rs1 = 0; v.e1 = 1; v.rd = 0; v.e3 = 1; tbl.push_back(v);
      v = idle(); v.rs1 = 0; v.e1 = 1; v.rs2 = 0; v.e2 = 1; tbl.push_back(v);
      v = idle(); v.iss = 1; v.ird = 7; tbl.push_back(v);
      v = idle(); v.lv = 1; v.lrd = 7; v.ldat = 32'h77; v.iss = 1; v.ird = 7;
      v.x_ready = 1; v.x_wren = 1; v.x_rd = 7; v.x_data = 32'h77; tbl.push_back(v);
      v = idle(); v.rd = 7; v.e3 = 1; v.x_haz = 1; tbl.push_back(v);
      v = idle(); v.rs2 = 7; v.e2 = 1; v.x_haz = 1; tbl.push_back(v);
      v = idle(); v.lv = 1; v.lrd = 7; v.ldat = 32'h70; v.rd = 7; v.e3 = 1;
      v.x_ready = 1; v.x_wren = 1; v.x_rd = 7; v.x_data = 32'h70; tbl.push_back(v);
      v = idle(); v.pw = 1; v.prd = 3; v.pdat = 32'h55; v.rs1 = 7; v.e1 = 1;
      v.x_wren = 1; v.x_rd = 3; v.x_data = 32'h55; tbl.push_back(v);
      v = idle(); v.pw = 1; v.prd = 0; v.pdat = 32'h66; v.lv = 1; v.lrd = 2; tbl.push_back(v);

      foreach (tbl[i]) run(tbl[i], 1'b1, $sformatf("vec%0d", i));

      for (int i = 0; i < 10; i++) run(idle(), 1'b1, $sformatf("idle%0d", i));

      // Starvation: four pipe wins, one forced LLU slot, then pipe again.
      for (int k = 0; k < 6; k++) begin
         v = contend(k);
         if (k == 4) v = drain_slot(v);
         run(v, 1'b1, $sformatf("starve%0d", k));
      end
      run(idle(), 1'b1, "gap0");

      // Forced slot with the LLU result withdrawn: stall, no write.
      for (int k = 0; k < 6; k++) begin
         v = contend(k);
         if (k == 4) begin
            v.lv = 0; v.x_stall = 1; v.x_wren = 0;
         end
         run(v, 1'b1, $sformatf("drop%0d", k));
      end
      run(idle(), 1'b1, "gap1");

      // Reset asserted in the forced slot with x5 and x7 busy.
      v = idle(); v.iss = 1; v.ird = 5; run(v, 1'b1, "rst_iss5");
      v = idle(); v.iss = 1; v.ird = 7; run(v, 1'b1, "rst_iss7");
      for (int k = 0; k < 4; k++) run(contend(k), 1'b1, $sformatf("rst_lose%0d", k));
      v = contend(4); v.rst = 0; v.x_wren = 0; run(v, 1'b1, "rst_drain");
      v = contend(5); v.rs1 = 5; v.e1 = 1; v.rs2 = 7; v.e2 = 1; run(v, 1'b1, "rst_rel");
      for (int k = 6; k < 9; k++) run(contend(k), 1'b1, $sformatf("rst_lose%0d", k));
      run(drain_slot(contend(9)), 1'b1, "rst_drain2");
      run(idle(), 1'b1, "gap2");

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         v = idle();
         v.rst  = ($urandom_range(0, 199) != 0);
         v.pw   = ($urandom_range(0, 99) < 70);
         v.prd  = 5'($urandom_range(0, 31));
         v.pdat = $urandom;
         v.lv   = ($urandom_range(0, 99) < 55);
         v.lrd  = 5'($urandom_range(0, 7));
         v.ldat = $urandom;
         v.iss  = ($urandom_range(0, 99) < 25);
         v.ird  = 5'($urandom_range(0, 7));
         v.rs1  = 5'($urandom_range(0, 7)); v.e1 = 1'($urandom_range(0, 1));
         v.rs2  = 5'($urandom_range(0, 7)); v.e2 = 1'($urandom_range(0, 1));
         v.rd   = 5'($urandom_range(0, 7)); v.e3 = 1'($urandom_range(0, 1));
         run(v, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Owns the single register-file write port.
- Arbitrates it between the in-order pipeline writeback (WB) and a long-latency unit (LLU, e.g. mul/div).
- Keeps a 32-entry busy scoreboard for LLU destinations and raises a decode hazard on RAW/WAW against busy registers.
- Guarantees LLU forward progress by briefly stalling WB; drives rd_wren/rd_addr/rd_data of the register file.

Parameters:
- XLEN, 32, data width.
- STARVE_MAX, 4, consecutive cycles an LLU result may lose arbitration before WB is stalled (legal range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pipe_wren  in  1  WB stage wants to write
- pipe_rd  in  5  WB destination
- pipe_data  in  XLEN  WB data
- ll_valid  in  1  LLU result valid
- ll_rd  in  5  LLU result destination
- ll_data  in  XLEN  LLU result data
- ll_ready  out  1  LLU result accepted this cycle
- ll_issue  in  1  an LLU op is dispatched this cycle
- ll_issue_rd  in  5  destination of dispatched LLU op
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage register addresses
- dec_rs1_rden, dec_rs2_rden, dec_rd_wren  in  1 each  decode-stage usage flags
- dec_hazard  out  1  decode must stall
- pipe_stall  out  1  WB must hold its instruction and retry next cycle
- rf_wren  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_data  out  XLEN  register-file write data

Behaviour:
- State: busy[31:0], starve counter cnt (4 b), FSM {ARB, DRAIN}. Reset: busy=0, cnt=0, FSM=ARB. All outputs are combinational from state and inputs, and are 0 while rst_n is low.
- The write mux is combinational (zero latency), so register-file bypass of same-cycle writes still works.
- ARB, grant rules:
  - pipe_wren=1: pipe wins.
  - else ll_valid=1: LLU wins, ll_ready=1.
  - Granted source drives rf_rd/rf_data. rf_wren=1 unless the granted rd==0. An LLU result to x0 is still handshaked (ll_ready=1) and discarded.
- Counter:
  - ll_valid=1 and pipe wins: cnt++.
  - LLU granted or ll_valid=0: cnt=0.
  - If cnt==STARVE_MAX-1 and the LLU loses again: next state DRAIN, cnt=0.
- DRAIN (exactly 1 cycle):
  - LLU has priority: ll_ready=ll_valid. pipe_stall=1 regardless of pipe_wren; the pipe write is not performed and WB retries next cycle.
  - Next state ARB.
  - If ll_valid dropped, the DRAIN cycle issues no write but still stalls.
- pipe_stall=0 in ARB.
- Scoreboard:
  - set busy[ll_issue_rd] on ll_issue when ll_issue_rd≠0.
  - clear busy[ll_rd] when ll_valid & ll_ready.
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is always 0.
- Hazard:
  - eff_busy = busy with the bit being cleared this cycle masked off. The same-cycle write is bypassed by the register file.
  - dec_hazard = (rs1_rden & eff_busy[rs1]) | (rs2_rden & eff_busy[rs2]) | (rd_wren & eff_busy[rd]).
  - Any field equal to 0 never causes a hazard.
- ll_issue is not gated by this block. Decode guarantees no issue while dec_hazard=1.
- Async reset mid-DRAIN: returns to ARB. Busy is cleared and in-flight LLU results are the LLU's responsibility to flush.

Test Plan:
- Reset, then ll_issue rd=5; next cycle dec_rs1=5, rs1_rden=1 -> dec_hazard=1. ll_valid rd=5, data 0xDEADBEEF, pipe_wren=0 -> ll_ready=1, rf_wren=1, rf_rd=5, rf_data=0xDEADBEEF, and dec_hazard=0 in that same cycle. busy[5]=0 after.
- ll_valid=1 held with pipe_wren=1 every cycle, STARVE_MAX=4 -> pipe granted for 4 cycles. 5th cycle pipe_stall=1, ll_ready=1, rf_rd=ll_rd. 6th cycle pipe granted again, pipe_stall=0.
- LLU result with ll_rd=0 and pipe_wren=0 -> ll_ready=1, rf_wren=0. ll_issue with rd=0 -> busy unchanged, no hazard on x0 reads.
- ll_issue rd=7 in the same cycle an LLU result for rd=7 is accepted -> busy[7]=1 afterwards. Decode dec_rd=7, rd_wren=1 -> dec_hazard=1.
- Assert rst_n=0 during DRAIN with busy=0x0000_00A0 -> immediately pipe_stall=0, ll_ready=0, rf_wren=0. After release busy=0, cnt=0, FSM=ARB.
- Both idle (pipe_wren=0, ll_valid=0) for 10 cycles -> rf_wren=0, cnt stays 0, no stall.
